// File: rtl/cheat_engine_if.sv
// Bus bundle between the SNES decode/host side and the cheat engine.
// master: SNES bus decode and programming host. slave: cheat_engine.
interface cheat_engine_if #(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned IDX_W     = $clog2(NUM_SLOTS) + 1
);
  logic [23:0]          SNES_ADDR;
  logic                 SNES_cycle_start;
  logic                 SNES_rd_strobe;
  logic                 SNES_reset_strobe;
  logic                 cheat_enable;
  logic                 pgm_we;
  logic [IDX_W-1:0]     pgm_idx;
  logic [31:0]          pgm_in;
  logic                 pgm_commit;
  logic                 commit_done;
  logic [7:0]           data_out;
  logic                 cheat_hit;
  logic [NUM_SLOTS-1:0] armed_mask;
  logic [IDX_W-2:0]     stat_idx;
  logic [7:0]           stat_out;

  modport master (
    output SNES_ADDR, SNES_cycle_start, SNES_rd_strobe, SNES_reset_strobe,
    output cheat_enable, pgm_we, pgm_idx, pgm_in, pgm_commit, stat_idx,
    input  commit_done, data_out, cheat_hit, armed_mask, stat_out
  );

  modport slave (
    input  SNES_ADDR, SNES_cycle_start, SNES_rd_strobe, SNES_reset_strobe,
    input  cheat_enable, pgm_we, pgm_idx, pgm_in, pgm_commit, stat_idx,
    output commit_done, data_out, cheat_hit, armed_mask, stat_out
  );
endinterface

// File: rtl/cheat_engine.sv
// cheat_engine: NUM_SLOTS address/data ROM patch slots with per-slot modes
// (off / always / one-shot / count-limited), shadow programming committed
// atomically while no patched read is in flight, and a 2-clk match pipeline.
// Optional build macro: CHEAT_HITCNT_EN adds per-slot saturating hit counters
// readable through stat_idx/stat_out.
module cheat_engine #(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned IDX_W     = $clog2(NUM_SLOTS) + 1
) (
  input logic          clk,
  input logic          rst,
  cheat_engine_if.slave bus
);
  localparam int unsigned SLOT_W = IDX_W - 1;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LIM_W  = 8;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_COUNT   = 2'b11;

  typedef enum logic [1:0] {C_IDLE, C_PEND, C_DONE} cstate_t;

  logic [ADDR_W-1:0] sh_addr   [NUM_SLOTS];
  logic [DATA_W-1:0] sh_data   [NUM_SLOTS];
  logic [1:0]        sh_mode   [NUM_SLOTS];
  logic [LIM_W-1:0]  sh_limit  [NUM_SLOTS];
  logic [ADDR_W-1:0] act_addr  [NUM_SLOTS];
  logic [DATA_W-1:0] act_data  [NUM_SLOTS];
  logic [1:0]        act_mode  [NUM_SLOTS];
  logic [LIM_W-1:0]  act_limit [NUM_SLOTS];
  logic [LIM_W-1:0]  remaining_q [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] armed_q;
  logic [NUM_SLOTS-1:0] match_q;
  logic [NUM_SLOTS-1:0] match_c;
  logic                 match_vld_q;
  logic [SLOT_W-1:0]    sel_q;
  logic [SLOT_W-1:0]    sel_c;
  logic                 cheat_hit_q;
  logic [DATA_W-1:0]    data_out_q;
  logic                 commit_done_q;
  cstate_t              cstate_q;
  cstate_t              cstate_c;
  logic                 commit_go_c;
  logic                 hit_c;
  logic [SLOT_W-1:0]    pgm_slot_c;
  logic                 pgm_ok_c;

  function automatic logic arm_rule(input logic [1:0] mode, input logic [LIM_W-1:0] limit);
    return (mode != MODE_OFF) && !((mode == MODE_COUNT) && (limit == '0));
  endfunction

  assign pgm_slot_c = bus.pgm_idx[IDX_W-1:1];
  assign pgm_ok_c   = bus.pgm_we && (32'(pgm_slot_c) < NUM_SLOTS);
  assign hit_c      = bus.SNES_rd_strobe && cheat_hit_q && bus.cheat_enable;

  // Shadow register writes; active set is untouched until a commit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sh_addr[i]  <= '0;
        sh_data[i]  <= '0;
        sh_mode[i]  <= MODE_OFF;
        sh_limit[i] <= '0;
      end
    end else if (pgm_ok_c) begin
      if (bus.pgm_idx[0]) begin
        sh_mode[pgm_slot_c]  <= bus.pgm_in[1:0];
        sh_limit[pgm_slot_c] <= bus.pgm_in[15:8];
      end else begin
        sh_addr[pgm_slot_c]  <= bus.pgm_in[31:8];
        sh_data[pgm_slot_c]  <= bus.pgm_in[7:0];
      end
    end
  end

  // Commit state register
  always_ff @(posedge clk) begin
    if (rst) begin
      cstate_q      <= C_IDLE;
      commit_done_q <= 1'b0;
    end else begin
      cstate_q      <= cstate_c;
      commit_done_q <= (cstate_q == C_DONE);
    end
  end

  // Commit next-state: wait for a clk with no patched read in flight
  always_comb begin
    cstate_c    = cstate_q;
    commit_go_c = 1'b0;
    case (cstate_q)
      C_IDLE: if (bus.pgm_commit) cstate_c = C_PEND;
      C_PEND: begin
        if (!cheat_hit_q) begin
          commit_go_c = 1'b1;
          cstate_c    = C_DONE;
        end
      end
      C_DONE: cstate_c = bus.pgm_commit ? C_PEND : C_IDLE;
      default: cstate_c = C_IDLE;
    endcase
  end

  // Address compare against the armed active slots
  always_comb begin
    match_c = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      match_c[i] = armed_q[i] && (bus.SNES_ADDR == act_addr[i]);
    end
  end

  // Lowest matching slot wins
  always_comb begin
    sel_c = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (match_q[i]) sel_c = SLOT_W'(i);
    end
  end

  // Two-stage match pipeline driving cheat_hit/data_out
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q     <= '0;
      match_vld_q <= 1'b0;
      sel_q       <= '0;
      cheat_hit_q <= 1'b0;
      data_out_q  <= '0;
    end else if (bus.SNES_reset_strobe) begin
      match_q     <= '0;
      match_vld_q <= 1'b0;
      sel_q       <= '0;
      cheat_hit_q <= 1'b0;
    end else begin
      if (bus.SNES_cycle_start) begin
        match_q     <= match_c;
        match_vld_q <= 1'b1;
        cheat_hit_q <= 1'b0;
      end else if (match_vld_q) begin
        match_vld_q <= 1'b0;
        cheat_hit_q <= bus.cheat_enable && (|match_q);
        if (|match_q) begin
          data_out_q <= act_data[sel_c];
          sel_q      <= sel_c;
        end
      end
      if (!bus.cheat_enable) cheat_hit_q <= 1'b0;
    end
  end

  // Active set, armed bits and remaining counts; commit overrides hit effects
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        act_addr[i]    <= '0;
        act_data[i]    <= '0;
        act_mode[i]    <= MODE_OFF;
        act_limit[i]   <= '0;
        remaining_q[i] <= '0;
      end
    end else begin
      if (hit_c) begin
        case (act_mode[sel_q])
          MODE_ONESHOT: armed_q[sel_q] <= 1'b0;
          MODE_COUNT: begin
            if (remaining_q[sel_q] != '0) begin
              remaining_q[sel_q] <= remaining_q[sel_q] - LIM_W'(1);
              if (remaining_q[sel_q] == LIM_W'(1)) armed_q[sel_q] <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      if (bus.SNES_reset_strobe) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          armed_q[i]     <= arm_rule(act_mode[i], act_limit[i]);
          remaining_q[i] <= act_limit[i];
        end
      end
      if (commit_go_c) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          act_addr[i]    <= sh_addr[i];
          act_data[i]    <= sh_data[i];
          act_mode[i]    <= sh_mode[i];
          act_limit[i]   <= sh_limit[i];
          armed_q[i]     <= arm_rule(sh_mode[i], sh_limit[i]);
          remaining_q[i] <= sh_limit[i];
        end
      end
    end
  end

  assign bus.commit_done = commit_done_q;
  assign bus.data_out    = data_out_q;
  assign bus.cheat_hit   = cheat_hit_q;
  assign bus.armed_mask  = armed_q;

`ifdef CHEAT_HITCNT_EN
  logic [7:0] hitcnt_q [NUM_SLOTS];
  logic [7:0] stat_q;

  // Per-slot saturating hit counters; a word1 write restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) hitcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (pgm_ok_c && bus.pgm_idx[0] && (pgm_slot_c == SLOT_W'(i))) begin
          hitcnt_q[i] <= '0;
        end else if (hit_c && (sel_q == SLOT_W'(i)) && (hitcnt_q[i] != 8'hFF)) begin
          hitcnt_q[i] <= hitcnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Registered counter readback
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= (32'(bus.stat_idx) < NUM_SLOTS) ? hitcnt_q[bus.stat_idx] : 8'h00;
    end
  end

  assign bus.stat_out = stat_q;
`else
  logic unused_stat_idx;
  assign unused_stat_idx = ^bus.stat_idx;
  assign bus.stat_out    = 8'h00;
`endif
endmodule

// File: tb/tb_cheat_engine.sv
// Directed bench for cheat_engine: modes, priority, commit timing, reset paths.
module tb_cheat_engine;
  localparam int unsigned NUM_SLOTS = 16;
  localparam int unsigned IDX_W     = $clog2(NUM_SLOTS) + 1;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  cheat_engine_if #(.NUM_SLOTS(NUM_SLOTS), .IDX_W(IDX_W)) bus ();

  cheat_engine #(.NUM_SLOTS(NUM_SLOTS), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] w0(input logic [23:0] a, input logic [7:0] d);
    return {a, d};
  endfunction

  function automatic logic [31:0] w1(input logic [1:0] m, input logic [7:0] lim);
    return {16'h0000, lim, 6'b000000, m};
  endfunction

  task automatic pgm_write(input int slot, input int word, input logic [31:0] val);
    bus.pgm_we  = 1'b1;
    bus.pgm_idx = IDX_W'((slot << 1) | word);
    bus.pgm_in  = val;
    tick();
    bus.pgm_we  = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.SNES_ADDR        = 24'h000000;
    bus.SNES_cycle_start = 1'b1;
    tick();
    bus.SNES_cycle_start = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_done(input string tag);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (bus.commit_done) done = 1'b1;
      else tick();
    end
    check(tag, 32'(done), 32'd1);
    tick();
  endtask

  task automatic commit(input string tag);
    idle_cycle();
    bus.pgm_commit = 1'b1;
    tick();
    bus.pgm_commit = 1'b0;
    wait_done(tag);
  endtask

  task automatic bus_read(input logic [23:0] a, output logic hit, output logic [7:0] d,
                          output logic hit_after);
    bus.SNES_ADDR        = a;
    bus.SNES_cycle_start = 1'b1;
    tick();
    bus.SNES_cycle_start = 1'b0;
    tick();
    hit = bus.cheat_hit;
    d   = bus.data_out;
    bus.SNES_rd_strobe = 1'b1;
    tick();
    bus.SNES_rd_strobe = 1'b0;
    hit_after = bus.cheat_hit;
    tick();
    tick();
  endtask

  initial begin
    logic       h;
    logic       ha;
    logic [7:0] d;
    checks = 0;
    passes = 0;
    rst = 1'b1;
    bus.SNES_ADDR = '0;
    bus.SNES_cycle_start = 1'b0;
    bus.SNES_rd_strobe = 1'b0;
    bus.SNES_reset_strobe = 1'b0;
    bus.cheat_enable = 1'b1;
    bus.pgm_we = 1'b0;
    bus.pgm_idx = '0;
    bus.pgm_in = '0;
    bus.pgm_commit = 1'b0;
    bus.stat_idx = '0;
    tick();
    tick();
    tick();
    check("rst_cheat_hit", 32'(bus.cheat_hit), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_armed", 32'(bus.armed_mask), 32'd0);
    check("rst_commit_done", 32'(bus.commit_done), 32'd0);
    check("rst_stat_out", 32'(bus.stat_out), 32'd0);
    rst = 1'b0;
    tick();

    // slot0 always-mode patch
    pgm_write(0, 0, w0(24'h00FFEA, 8'h04));
    pgm_write(0, 1, w1(2'b01, 8'h00));
    commit("commit_slot0");
    check("armed_slot0", 32'(bus.armed_mask), 32'h0001);
    bus_read(24'h00FFEA, h, d, ha);
    check("always_hit1", 32'(h), 32'd1);
    check("always_data1", 32'(d), 32'h04);
    bus_read(24'h00FFEA, h, d, ha);
    check("always_hit2", 32'(h), 32'd1);
    check("always_data2", 32'(d), 32'h04);
    bus_read(24'h123456, h, d, ha);
    check("miss_hit", 32'(h), 32'd0);
    check("miss_data_hold", 32'(d), 32'h04);

    // priority between slots 2 and 5
    pgm_write(2, 0, w0(24'h808000, 8'h11));
    pgm_write(2, 1, w1(2'b01, 8'h00));
    pgm_write(5, 0, w0(24'h808000, 8'h55));
    pgm_write(5, 1, w1(2'b01, 8'h00));
    commit("commit_prio");
    bus_read(24'h808000, h, d, ha);
    check("prio_hit", 32'(h), 32'd1);
    check("prio_low_wins", 32'(d), 32'h11);
    pgm_write(2, 1, w1(2'b00, 8'h00));
    commit("commit_disarm2");
    check("armed_after_disarm", 32'(bus.armed_mask), 32'h0021);
    bus_read(24'h808000, h, d, ha);
    check("prio_slot5", 32'(d), 32'h55);

    // one-shot slot1
    pgm_write(1, 0, w0(24'h7E0010, 8'hAA));
    pgm_write(1, 1, w1(2'b10, 8'h00));
    commit("commit_oneshot");
    check("armed_oneshot", 32'(bus.armed_mask), 32'h0023);
    bus_read(24'h7E0010, h, d, ha);
    check("oneshot_hit", 32'(h), 32'd1);
    check("oneshot_data", 32'(d), 32'hAA);
    check("oneshot_hold", 32'(ha), 32'd1);
    check("oneshot_disarm", 32'(bus.armed_mask), 32'h0021);
    bus_read(24'h7E0010, h, d, ha);
    check("oneshot_second_miss", 32'(h), 32'd0);
    bus.SNES_reset_strobe = 1'b1;
    tick();
    bus.SNES_reset_strobe = 1'b0;
    check("snes_reset_rearm", 32'(bus.armed_mask), 32'h0023);
    bus_read(24'h7E0010, h, d, ha);
    check("oneshot_rearmed_hit", 32'(h), 32'd1);

    // count-limited slot3
    pgm_write(3, 0, w0(24'h7E2000, 8'h33));
    pgm_write(3, 1, w1(2'b11, 8'h03));
    commit("commit_count");
    check("armed_count", 32'(bus.armed_mask), 32'h002B);
    for (int k = 0; k < 3; k++) begin
      bus_read(24'h7E2000, h, d, ha);
      check("count_hit", 32'(h), 32'd1);
    end
    bus_read(24'h7E2000, h, d, ha);
    check("count_fourth_miss", 32'(h), 32'd0);
    check("count_disarmed", 32'(bus.armed_mask[3]), 32'd0);
    bus.SNES_reset_strobe = 1'b1;
    tick();
    bus.SNES_reset_strobe = 1'b0;
    check("count_rearm", 32'(bus.armed_mask[3]), 32'd1);
    pgm_write(3, 1, w1(2'b11, 8'h00));
    commit("commit_limit0");
    check("limit0_unarmed", 32'(bus.armed_mask[3]), 32'd0);

    // commit requested while a patched read is in flight
    pgm_write(0, 0, w0(24'h00FFEA, 8'h99));
    bus.SNES_ADDR = 24'h00FFEA;
    bus.SNES_cycle_start = 1'b1;
    tick();
    bus.SNES_cycle_start = 1'b0;
    tick();
    check("inflight_hit", 32'(bus.cheat_hit), 32'd1);
    check("inflight_old_data", 32'(bus.data_out), 32'h04);
    bus.pgm_commit = 1'b1;
    tick();
    bus.pgm_commit = 1'b0;
    tick();
    tick();
    check("commit_held_off", 32'(bus.commit_done), 32'd0);
    check("inflight_data_kept", 32'(bus.data_out), 32'h04);
    bus.SNES_ADDR = 24'h000000;
    bus.SNES_cycle_start = 1'b1;
    tick();
    bus.SNES_cycle_start = 1'b0;
    wait_done("commit_after_hit");
    bus_read(24'h00FFEA, h, d, ha);
    check("new_data_after_commit", 32'(d), 32'h99);

    // global enable off
    bus.cheat_enable = 1'b0;
    bus_read(24'h00FFEA, h, d, ha);
    check("disabled_no_hit", 32'(h), 32'd0);
    bus.cheat_enable = 1'b1;

`ifdef CHEAT_HITCNT_EN
    bus.stat_idx = '0;
    pgm_write(0, 1, w1(2'b01, 8'h00));
    tick();
    tick();
    check("hitcnt_cleared", 32'(bus.stat_out), 32'd0);
    for (int k = 0; k < 5; k++) bus_read(24'h00FFEA, h, d, ha);
    check("hitcnt_5", 32'(bus.stat_out), 32'd5);
    for (int k = 0; k < 295; k++) bus_read(24'h00FFEA, h, d, ha);
    check("hitcnt_sat", 32'(bus.stat_out), 32'hFF);
    pgm_write(0, 1, w1(2'b01, 8'h00));
    tick();
    tick();
    check("hitcnt_rewrite", 32'(bus.stat_out), 32'd0);
`else
    check("stat_tied_zero", 32'(bus.stat_out), 32'd0);
`endif

    // synchronous reset in the middle of a patched cycle
    bus.SNES_ADDR = 24'h00FFEA;
    bus.SNES_cycle_start = 1'b1;
    tick();
    bus.SNES_cycle_start = 1'b0;
    tick();
    check("pre_rst_hit", 32'(bus.cheat_hit), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_hit", 32'(bus.cheat_hit), 32'd0);
    check("mid_rst_data", 32'(bus.data_out), 32'd0);
    check("mid_rst_armed", 32'(bus.armed_mask), 32'd0);
    check("mid_rst_done", 32'(bus.commit_done), 32'd0);
    check("mid_rst_stat", 32'(bus.stat_out), 32'd0);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
